// File: rtl/secsys_pkg.sv
// rtl/secsys_pkg.sv - shared types, constants and helpers for the multi-zone alarm controller
package secsys_pkg;

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        ARMING   = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    // Zone 0 (gas) instant, every other zone delayed.
    localparam logic [15:0] DEF_DLY_MASK = 16'hFFFE;

    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - siren square wave, high phase first, phase restarts when en rises
module tone_gen
    import secsys_pkg::*;
#(
    parameter int TONE_DIV = 8,
    parameter int CNT_W    = cnt_w(TONE_DIV, TONE_DIV, TONE_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sound
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TONE_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             sound_q, sound_d;

    always_comb begin
        cnt_d   = cnt_q;
        sound_d = sound_q;
        en_d    = en;
        if (!en) begin
            cnt_d   = '0;
            sound_d = 1'b0;
        end else if (!en_q) begin
            cnt_d   = RELOAD;
            sound_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = RELOAD;
            sound_d = ~sound_q;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            en_q    <= 1'b0;
            sound_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            sound_q <= sound_d;
        end
    end

    assign sound = sound_q;

endmodule

// File: rtl/alarm_ctrl_multi.sv
// rtl/alarm_ctrl_multi.sv - multi-zone alarm FSM with exit/entry delays; SECSYS_FAILCNT_EN adds a wrong-code limit
module alarm_ctrl_multi
    import secsys_pkg::*;
#(
    parameter int                  N_ZONES   = 4,
    parameter logic [N_ZONES-1:0]  DLY_MASK  = DEF_DLY_MASK[N_ZONES-1:0],
    parameter int                  EXIT_DLY  = 32,
    parameter int                  ENTRY_DLY = 64,
    parameter int                  TONE_DIV  = 8,
    parameter int                  MAX_FAILS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_on,
    input  logic [N_ZONES-1:0] zona,
    input  logic               clave_vld,
    input  logic               clave_ok,
    output logic               led,
    output logic               sound,
    output logic               mensaje,
    output logic [N_ZONES-1:0] zonas_lat,
    output logic               armed
);

    localparam int               CNT_W    = cnt_w(EXIT_DLY, ENTRY_DLY, TONE_DIV);
    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DLY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_ZONES-1:0] lat_q, lat_d;
    logic               led_q, led_d;
    logic               armed_q, armed_d;
    logic               mensaje_q, mensaje_d;

    logic good, inst_hit, dly_hit, fail_hit;

    assign good     = clave_vld & clave_ok;
    assign inst_hit = |(zona & ~DLY_MASK);
    assign dly_hit  = |(zona & DLY_MASK);

`ifdef SECSYS_FAILCNT_EN
    localparam int             FAIL_W   = $clog2(MAX_FAILS + 1);
    localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAILS);

    logic [FAIL_W-1:0] fail_q, fail_d;
    logic              bad;

    assign bad = clave_vld & ~clave_ok;

    always_comb begin
        fail_d = fail_q;
        if (good)
            fail_d = '0;
        else if (bad && fail_q < FAIL_LIM)
            fail_d = fail_q + FAIL_W'(1);
    end

    assign fail_hit = bad && (fail_d == FAIL_LIM);

    always_ff @(posedge clk) begin
        if (rst) fail_q <= '0;
        else     fail_q <= fail_d;
    end
`else
    assign fail_hit = (MAX_FAILS < 0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DISARMED: begin
                if (sw_on) begin
                    state_d = ARMING;
                    cnt_d   = EXIT_LD;
                end
            end
            ARMING: begin
                if (!sw_on || good)    state_d = DISARMED;
                else if (fail_hit)     state_d = ALARM;
                else if (cnt_q == '0)  state_d = ARMED;
                else                   cnt_d   = cnt_q - CNT_W'(1);
            end
            ARMED: begin
                if (good || !sw_on)           state_d = DISARMED;
                else if (inst_hit || fail_hit) state_d = ALARM;
                else if (dly_hit) begin
                    state_d = ENTRY;
                    cnt_d   = ENTRY_LD;
                end
            end
            ENTRY: begin
                if (good)                      state_d = DISARMED;
                else if (inst_hit || fail_hit) state_d = ALARM;
                else if (cnt_q == '0)          state_d = ALARM;
                else                           cnt_d   = cnt_q - CNT_W'(1);
            end
            ALARM: begin
                if (good) state_d = DISARMED;
            end
            default: state_d = DISARMED;
        endcase

        if (state_d == DISARMED)   cnt_d = '0;

        lat_d = lat_q;
        if (state_d == ALARM)         lat_d = lat_q | zona;
        else if (state_d == DISARMED) lat_d = '0;

        led_d     = (state_d != DISARMED);
        armed_d   = (state_d == ARMED) || (state_d == ENTRY);
        mensaje_d = (state_d == ALARM) && (state_q != ALARM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DISARMED;
            cnt_q     <= '0;
            lat_q     <= '0;
            led_q     <= 1'b0;
            armed_q   <= 1'b0;
            mensaje_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            led_q     <= led_d;
            armed_q   <= armed_d;
            mensaje_q <= mensaje_d;
        end
    end

    // Driven from next state so the siren is high in the same cycle ALARM is entered.
    tone_gen #(
        .TONE_DIV (TONE_DIV),
        .CNT_W    (CNT_W)
    ) u_tone (
        .clk   (clk),
        .rst   (rst),
        .en    (state_d == ALARM),
        .sound (sound)
    );

    assign led       = led_q;
    assign armed     = armed_q;
    assign mensaje   = mensaje_q;
    assign zonas_lat = lat_q;

endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// tb/tb_alarm_ctrl_multi.sv - directed self-checking bench for alarm_ctrl_multi
module tb_alarm_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_on;
    logic [3:0] zona;
    logic       clave_vld;
    logic       clave_ok;
    logic       led, sound, mensaje, armed;
    logic [3:0] zonas_lat;

    int vectors = 0;
    int miscompares = 0;

    alarm_ctrl_multi dut (
        .clk       (clk),
        .rst       (rst),
        .sw_on     (sw_on),
        .zona      (zona),
        .clave_vld (clave_vld),
        .clave_ok  (clave_ok),
        .led       (led),
        .sound     (sound),
        .mensaje   (mensaje),
        .zonas_lat (zonas_lat),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic code(input logic ok);
        clave_vld = 1'b1;
        clave_ok  = ok;
        step(1);
        clave_vld = 1'b0;
        clave_ok  = 1'b0;
    endtask

    task automatic arm_fully(input string tag);
        sw_on = 1'b1;
        step(1);
        step(32);
        chk({tag, "_armed"}, armed, 1);
    endtask

    initial begin
        rst = 1'b1; sw_on = 1'b0; zona = '0; clave_vld = 1'b0; clave_ok = 1'b0;
        step(2);
        rst = 1'b0;
        chk("rst_led", led, 0);
        chk("rst_sound", sound, 0);
        chk("rst_msg", mensaje, 0);
        chk("rst_armed", armed, 0);
        chk("rst_lat", zonas_lat, 0);

        // exit delay with zone 1 pulsed while ARMING
        sw_on = 1'b1;
        step(1);
        chk("arming_led", led, 1);
        chk("arming_armed", armed, 0);
        step(4);
        zona = 4'b0010;
        step(3);
        zona = 4'b0000;
        chk("arming_ignore_zone", led & ~armed & ~mensaje, 1);
        step(24);
        chk("exit_k31_armed", armed, 0);
        step(1);
        chk("exit_k32_armed", armed, 1);

        // delayed zone, entry delay expires
        zona = 4'b0010;
        step(1);
        chk("entry_armed", armed, 1);
        step(63);
        chk("entry_k63_armed", armed, 1);
        chk("entry_k63_msg", mensaje, 0);
        step(1);
        chk("alarm_msg", mensaje, 1);
        chk("alarm_armed", armed, 0);
        chk("alarm_sound0", sound, 1);
        chk("alarm_lat", zonas_lat, 4'b0010);
        step(1);
        chk("alarm_msg_fall", mensaje, 0);
        step(6);
        chk("tone_a7", sound, 1);
        step(1);
        chk("tone_a8", sound, 0);
        step(7);
        chk("tone_a15", sound, 0);
        step(1);
        chk("tone_a16", sound, 1);

        // sw_on ignored in ALARM, good code exits
        sw_on = 1'b0;
        zona = 4'b0000;
        step(5);
        chk("alarm_swoff_led", led, 1);
        chk("alarm_swoff_lat", zonas_lat, 4'b0010);
        code(1'b1);
        chk("disarm_led", led, 0);
        chk("disarm_sound", sound, 0);
        chk("disarm_lat", zonas_lat, 0);
        chk("disarm_msg", mensaje, 0);

        // good code at entry cycle 63
        arm_fully("rearm1");
        zona = 4'b0100;
        step(1);
        zona = 4'b0000;
        step(62);
        sw_on = 1'b0;
        code(1'b1);
        chk("entry_code_led", led, 0);
        chk("entry_code_armed", armed, 0);
        step(1);
        chk("entry_code_no_msg", mensaje, 0);
        step(3);
        chk("entry_code_quiet", led | sound | mensaje, 0);

        // gas hit during ENTRY
        arm_fully("rearm2");
        zona = 4'b0100;
        step(1);
        zona = 4'b0000;
        step(10);
        chk("gas_pre_msg", mensaje, 0);
        zona = 4'b0001;
        step(1);
        chk("gas_msg", mensaje, 1);
        chk("gas_lat", zonas_lat, 4'b0001);
        chk("gas_sound", sound, 1);

        // reset mid-ALARM
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        zona = 4'b0000;
        sw_on = 1'b0;
        chk("midrst_all", {led, sound, mensaje, armed, zonas_lat}, 0);

        // good code on the exit-expiry edge
        sw_on = 1'b1;
        step(1);
        step(31);
        code(1'b1);
        chk("tie_armed", armed, 0);
        chk("tie_led", led, 0);
        sw_on = 1'b0;
        step(2);

        // three wrong codes in ARMED
        arm_fully("rearm3");
        code(1'b0);
        step(1);
        code(1'b0);
        step(1);
        chk("bad2_armed", armed, 1);
        code(1'b0);
`ifdef SECSYS_FAILCNT_EN
        chk("bad3_msg", mensaje, 1);
        chk("bad3_armed", armed, 0);
        chk("bad3_lat", zonas_lat, 0);
`else
        chk("bad3_msg", mensaje, 0);
        chk("bad3_armed", armed, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
